tetris_cmd_sched: RTL

// - Command scheduler in front of the tetris game core; drives its 3-bit ctrl input.
// - Arbitrates button pulses and an internal level-scaled gravity timer into one command.
// - Each command is a single-cycle code, followed by a guard gap while the core's FSM settles.
// - Requests arriving during the gap are held as pending bits, never dropped.

---
 rtl/tetris_cmd_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tetris_cmd_sched.sv
// ---------------------------------------------------------------------------
// tetris_cmd_sched
//
// Command scheduler in front of the tetris game core. It merges button pulses
// and a level-scaled gravity timer into one registered 3-bit command code on
// ctrl. Each code lasts one cycle and is followed by a guard gap. Requests that
// arrive during the gap are held as pending bits and issued later.
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   start       in   1  pulse: leave INIT/END, arm gravity
//   btn_hold    in   1  pulse: request hold
//   btn_rotate  in   1  pulse: request rotate
//   btn_left    in   1  pulse: request left move
//   btn_right   in   1  pulse: request right move
//   btn_down    in   1  pulse: request soft drop
//   btn_drop    in   1  pulse: request hard drop
//   left_held   in   1  level: left held (auto-repeat build only)
//   right_held  in   1  level: right held (auto-repeat build only)
//   pause       in   1  level: block issue, freeze gravity
//   level       in   4  speed level 0..15
//   ctrl        out  3  0 idle,1 hold,2 rot,3 L,4 R,5 down,6 drop,7 start
//   busy        out  1  high while in the guard gap
//   grav_tick   out  1  one-cycle pulse on each gravity expiry
//
// Build option: define TETRIS_SCHED_DAS_EN to enable held-button auto-repeat
// of left/right. Without it the held inputs are ignored.
// ---------------------------------------------------------------------------
module tetris_cmd_sched #(
  parameter int unsigned GRAV_BASE = 50_000_000,
  parameter int unsigned GRAV_STEP = 3_000_000,
  parameter int unsigned GRAV_MIN  = 5_000_000,
  parameter int unsigned CMD_GAP   = 4,
  parameter int unsigned DROP_GAP  = 48,
  parameter int unsigned DAS_DELAY = 10_000_000,
  parameter int unsigned DAS_RATE  = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_hold,
  input  logic       btn_rotate,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_drop,
  input  logic       left_held,
  input  logic       right_held,
  input  logic       pause,
  input  logic [3:0] level,
  output logic [2:0] ctrl,
  output logic       busy,
  output logic       grav_tick
);

  localparam int unsigned GAP_MAX = (DROP_GAP > CMD_GAP) ? DROP_GAP : CMD_GAP;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [7:1]         pending, set_vec, clr_vec;
  logic [7:0]         clr_onehot;
  logic [2:0]         win_code;
  logic               issue;
  logic [31:0]        grav_cnt, grav_dec, grav_sub, grav_period;
  logic               grav_armed, grav_expire;
  logic               das_l, das_r;

  // ---------------------------------------------------------------------
  // Auto-repeat for held left/right buttons
  // ---------------------------------------------------------------------
`ifdef TETRIS_SCHED_DAS_EN
  logic [31:0] das_cnt;
  logic        das_fire;

  assign das_fire = (left_held | right_held) && (das_cnt == DAS_DELAY - 32'd1);
  assign das_l    = das_fire & left_held;
  assign das_r    = das_fire & ~left_held;

  // After the first fire the counter is rewound so the next fire lands
  // DAS_RATE cycles later, reusing the same terminal compare.
  always_ff @(posedge clk) begin
    if (reset)                          das_cnt <= '0;
    else if (!(left_held | right_held)) das_cnt <= '0;
    else if (das_fire)                  das_cnt <= DAS_DELAY - DAS_RATE;
    else                                das_cnt <= das_cnt + 32'd1;
  end
`else
  logic unused_held;
  assign unused_held = left_held ^ right_held;
  assign das_l       = 1'b0;
  assign das_r       = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Gravity period: max(GRAV_MIN, GRAV_BASE - level*GRAV_STEP), saturating
  // ---------------------------------------------------------------------
  always_comb begin
    grav_dec    = 32'(level) * GRAV_STEP;
    grav_sub    = (GRAV_BASE > grav_dec) ? (GRAV_BASE - grav_dec) : 32'd0;
    grav_period = (grav_sub < GRAV_MIN) ? GRAV_MIN : grav_sub;
  end

  // >= rather than == so a level raise that overtakes the count still fires.
  assign grav_expire = grav_armed && !pause && (grav_cnt >= grav_period - 32'd1);

  // ---------------------------------------------------------------------
  // Request arbitration: 7 > 6 > 1 > 2 > 3 > 4 > 5
  // ---------------------------------------------------------------------
  assign set_vec = {start, btn_drop, btn_down | grav_expire, btn_right | das_r,
                    btn_left | das_l, btn_rotate, btn_hold};

  always_comb begin
    win_code = 3'd0;
    if      (pending[7]) win_code = 3'd7;
    else if (pending[6]) win_code = 3'd6;
    else if (pending[1]) win_code = 3'd1;
    else if (pending[2]) win_code = 3'd2;
    else if (pending[3]) win_code = 3'd3;
    else if (pending[4]) win_code = 3'd4;
    else if (pending[5]) win_code = 3'd5;
  end

  // ---------------------------------------------------------------------
  // Issue / gap FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_cnt;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!pause && (win_code != 3'd0)) begin
          issue   = 1'b1;
          state_d = ST_GAP;
          gap_d   = (win_code >= 3'd5) ? GAP_W'(DROP_GAP) : GAP_W'(CMD_GAP);
        end
      end
      ST_GAP: begin
        // The gap keeps running while paused; busy lasts exactly gap cycles.
        gap_d = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_onehot = 8'd1 << win_code;
  assign clr_vec    = issue ? clr_onehot[7:1] : 7'd0;
  assign busy       = (state_q == ST_GAP);

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_cnt    <= '0;
      pending    <= '0;
      ctrl       <= 3'd0;
      grav_cnt   <= '0;
      grav_armed <= 1'b0;
      grav_tick  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt   <= gap_d;
      // Set after clear: a new request on the bit being issued survives.
      pending   <= (pending & ~clr_vec) | set_vec;
      ctrl      <= issue ? win_code : 3'd0;
      grav_tick <= grav_expire;
      if (issue && (win_code == 3'd7)) grav_armed <= 1'b1;
      // Issuing a down step restarts the full gravity period.
      if (grav_expire || (issue && (win_code == 3'd5))) grav_cnt <= '0;
      else if (grav_armed && !pause)                    grav_cnt <= grav_cnt + 32'd1;
    end
  end

endmodule
